// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter; the timeout feature is built only when BUS_ARB_TIMEOUT_EN is defined.
// Latency: REQ->GNT 1 edge, REQ->EN 2 edges, release->EN low 1 edge, then TURN_CYCLES dead cycles.
// Backpressure: requesters hold REQ until served; requests are not latched outside arbitration points.
module bus_arbiter #(
  parameter int N           = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 abort
);

  localparam int PW = $clog2(N);
  localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_DRIVE, S_TURN} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] win_idx;
  logic          win_vld;
  logic [2:0]    turn_cnt;

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Scan downwards so the lowest offset from ptr wins.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    j       = 0;
    idx     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign nxt_ptr = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      en       <= '0;
      busy     <= 1'b0;
      turn_cnt <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt <= '0;
      abort    <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      abort <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state <= S_ARM;
            owner <= win_idx;
            gnt   <= onehot(win_idx);
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (req[owner]) begin
            state <= S_DRIVE;
            en    <= gnt;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            // Nothing was driven, so skip turnaround and keep the pointer.
            state <= S_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (!req[owner]) begin
            state    <= S_TURN;
            gnt      <= '0;
            en       <= '0;
            ptr      <= nxt_ptr;
            turn_cnt <= TURN_LAST;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (hold_cnt >= HOLD_LAST) begin
            state    <= S_TURN;
            gnt      <= '0;
            en       <= '0;
            ptr      <= nxt_ptr;
            turn_cnt <= TURN_LAST;
            abort    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        S_TURN: begin
          if (turn_cnt == 3'd0) begin
            if (win_vld) begin
              state <= S_ARM;
              owner <= win_idx;
              gnt   <= onehot(win_idx);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_en_onehot0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en));
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_en_gnt:      assert property (@(posedge clk) disable iff (!rst_n) (en != '0) |-> (en == gnt));
  a_no_handoff:  assert property (@(posedge clk) disable iff (!rst_n)
                                  (en != '0 && $past(en) != '0) |-> (en == $past(en)));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N=4, TURN_CYCLES=1, MAX_HOLD=8).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [3:0] en;
  logic [1:0] owner;
  logic       busy;
  logic       abort;
  logic [3:0] prev_en = 4'b0000;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.N(4), .TURN_CYCLES(1), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .en(en),
    .owner(owner), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic [3:0] e, input logic b);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_en"}, 32'(en), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic arst();
    #2 rst_n = 1'b0;
    #1;
    outs("arst", 4'b0000, 4'b0000, 1'b0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_abort", 32'(abort), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Bus invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      assert ($onehot0(en) && $onehot0(gnt) && (en == 4'b0 || en == gnt) &&
              (prev_en == 4'b0 || en == 4'b0 || en == prev_en)) else begin
        miscompares++;
        $error("FAIL invariant: observed gnt=%b en=%b prev_en=%b required one-hot, en==gnt, no handoff",
               gnt, en, prev_en);
      end
    end
    prev_en = en;
  end

  initial begin
    // Reset state, no clock edge needed.
    #1;
    outs("rst", 4'b0000, 4'b0000, 1'b0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    #7 rst_n = 1'b1;

    // Basic grant.
    req = 4'b0001;
    tick(); outs("basic_arm", 4'b0001, 4'b0000, 1'b1);
    chk("basic_owner", 32'(owner), 32'd0);
    tick(); outs("basic_drive", 4'b0001, 4'b0001, 1'b1);
    tick(); outs("basic_hold", 4'b0001, 4'b0001, 1'b1);
    req = 4'b0000;
    tick(); outs("basic_turn", 4'b0000, 4'b0000, 1'b1);
    tick(); outs("basic_idle", 4'b0000, 4'b0000, 1'b0);
    chk("basic_owner_hold", 32'(owner), 32'd0);

    // Simultaneous requests (ptr=1 now).
    req = 4'b0110;
    tick(); outs("sim_arm1", 4'b0010, 4'b0000, 1'b1);
    chk("sim_owner1", 32'(owner), 32'd1);
    tick(); outs("sim_drive1", 4'b0010, 4'b0010, 1'b1);
    req = 4'b0100;
    tick(); outs("sim_turn", 4'b0000, 4'b0000, 1'b1);
    tick(); outs("sim_arm2", 4'b0100, 4'b0000, 1'b1);
    chk("sim_owner2", 32'(owner), 32'd2);
    tick(); outs("sim_drive2", 4'b0100, 4'b0100, 1'b1);
    req = 4'b0000;
    tick(); outs("sim_turn2", 4'b0000, 4'b0000, 1'b1);
    tick(); outs("sim_idle", 4'b0000, 4'b0000, 1'b0);

    // Async reset mid-DRIVE (ptr=3: scan 3,0,1 picks 1).
    req = 4'b0010;
    tick(); outs("ar_arm", 4'b0010, 4'b0000, 1'b1);
    tick(); outs("ar_drive", 4'b0010, 4'b0010, 1'b1);
    req = 4'b0000;
    arst();
    req = 4'b0010;
    tick(); outs("ar_regrant", 4'b0010, 4'b0000, 1'b1);
    chk("ar_owner", 32'(owner), 32'd1);
    req = 4'b0000;
    arst();

    // ARM withdrawal keeps ptr at 0.
    req = 4'b0100;
    tick(); outs("wd_arm", 4'b0100, 4'b0000, 1'b1);
    req = 4'b0000;
    tick(); outs("wd_idle", 4'b0000, 4'b0000, 1'b0);
    req = 4'b0101;
    tick(); outs("wd_next", 4'b0001, 4'b0000, 1'b1);
    chk("wd_owner", 32'(owner), 32'd0);
    req = 4'b0000;
    tick(); outs("wd_drop", 4'b0000, 4'b0000, 1'b0);
    arst();

    // Fairness with all requesting, including the wrap back to 0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); outs($sformatf("fair%0d_arm", k), oh(k % 4), 4'b0000, 1'b1);
      tick(); outs($sformatf("fair%0d_d1", k), oh(k % 4), oh(k % 4), 1'b1);
      tick(); outs($sformatf("fair%0d_d2", k), oh(k % 4), oh(k % 4), 1'b1);
      req = 4'b1111 & ~oh(k % 4);
      tick(); outs($sformatf("fair%0d_turn", k), 4'b0000, 4'b0000, 1'b1);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick(); outs("fair_idle", 4'b0000, 4'b0000, 1'b0);
    arst();

    // Hold limit behaviour.
    req = 4'b0011;
    tick(); outs("to_arm", 4'b0001, 4'b0000, 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      tick(); outs($sformatf("to_drive%0d", c), 4'b0001, 4'b0001, 1'b1);
      chk($sformatf("to_abort%0d", c), 32'(abort), 32'd0);
    end
    tick(); outs("to_turn", 4'b0000, 4'b0000, 1'b1);
    chk("to_abort_pulse", 32'(abort), 32'd1);
    tick(); outs("to_regrant", 4'b0010, 4'b0000, 1'b1);
    chk("to_abort_clear", 32'(abort), 32'd0);
    chk("to_owner", 32'(owner), 32'd1);
`else
    for (int c = 0; c < 20; c++) begin
      tick(); outs($sformatf("nto_drive%0d", c), 4'b0001, 4'b0001, 1'b1);
      chk($sformatf("nto_abort%0d", c), 32'(abort), 32'd0);
    end
`endif
    req = 4'b0000;
    tick();
    arst();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
